// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, one bit position per clock,
// with a start/busy/done handshake for the multicycle control FSM.
module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] ONE =
    SHAMT_W'(1);

  state_t             state;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   step;

  always_comb begin
    step = data_out;
    unique case (op_q)
      OP_SLL: step = {data_out[WIDTH-2:0], 1'b0};
      OP_SRL: step = {1'b0, data_out[WIDTH-1:1]};
      OP_SRA: step = {data_out[WIDTH-1],
                      data_out[WIDTH-1:1]};
      OP_ROR: step = {data_out[0],
                      data_out[WIDTH-1:1]};
      default: step = data_out;
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_SLL;
      count    <= '0;
      data_out <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            data_out <= data_in;
            op_q     <= op;
            count    <= shamt;
            state    <= (shamt != '0) ? SHIFT : DONE;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          data_out <= step;
          if (count != '0) begin
            count <= count - ONE;
          end
          if (count <= ONE) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: vector table, random ops against a
// reference model, and hand-written multi-cycle corner sequences.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [1:0] o, input logic [31:0] d,
    input logic [4:0] s);
    case (o)
      2'b00: model = d << s;
      2'b01: model = d >> s;
      2'b10: model = $signed(d) >>> s;
      default:
        model = (s == 0) ? d :
                ((d >> s) | (d << (6'd32 - {1'b0, s})));
    endcase
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got %h", data_out);
      end else begin
        chk("sb_result", data_out, sb_q.pop_front());
      end
    end
  end

  // Drive one op at a negedge; track busy/done latency.
  // poke>0 pulses start with junk operands at that cycle.
  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] d,
                       input logic [4:0] s,
                       input logic [31:0] exp,
                       input int poke);
    int nb;
    int lat;
    bit got;
    nb = 0; lat = 0; got = 0;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; shamt = s;
    sb_q.push_back(exp);
    for (int i = 1; i <= int'(s) + 4 && !got; i++) begin
      @(negedge clk);
      if (poke != 0 && i == poke) begin
        start = 1'b1; op = 2'b11;
        data_in = $urandom; shamt = 5'd3;
      end else begin
        start = 1'b0;
        data_in = $urandom;
        op = 2'($urandom_range(0, 3));
      end
      if (busy) nb++;
      if (done) begin got = 1; lat = i; end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", lat, int'(s) + 1);
    chk("busy_cycles", nb, int'(s));
    @(negedge clk);
    chk("idle_after", {busy, done}, 2'b00);
    chk("hold_result", data_out, exp);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'h00000001, 5'd2,  32'h00000004};
    vecs[1]  = '{2'b00, 32'h0000003C, 5'd2,  32'h000000F0};
    vecs[2]  = '{2'b10, 32'h80000000, 5'd4,  32'hF8000000};
    vecs[3]  = '{2'b01, 32'h80000000, 5'd4,  32'h08000000};
    vecs[4]  = '{2'b10, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF};
    vecs[5]  = '{2'b11, 32'h00000001, 5'd1,  32'h80000000};
    vecs[6]  = '{2'b11, 32'h12345678, 5'd0,  32'h12345678};
    vecs[7]  = '{2'b01, 32'h12345678, 5'd8,  32'h00123456};
    vecs[8]  = '{2'b11, 32'h12345678, 5'd4,  32'h81234567};
    vecs[9]  = '{2'b11, 32'h80000001, 5'd31, 32'h00000003};
    vecs[10] = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    vecs[11] = '{2'b00, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5};

    reset = 1'b1; start = 1'b1; op = 2'b00;
    data_in = 32'hDEADBEEF; shamt = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {busy, done}, 2'b00);
    chk("reset_data", data_out, 32'h0);
    reset = 1'b0; start = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].d, vecs[i].sh,
            vecs[i].exp, 0);

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  o;
      logic [31:0] d;
      logic [4:0]  s;
      o = 2'($urandom_range(0, 3));
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      do_op(o, d, s, model(o, d, s), 0);
    end

    // Start pulsed mid-shift must be ignored.
    do_op(2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000, 5);

    // Reset after three shift cycles.
    @(negedge clk);
    start = 1'b1; op = 2'b01;
    data_in = 32'hF0000000; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_flags", {busy, done}, 2'b00);
    chk("rst_mid_data", data_out, 32'h0);
    reset = 1'b0;
    do_op(2'b00, 32'h00000001, 5'd1, 32'h00000002, 0);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b00;
    data_in = 32'h00000001; shamt = 5'd2;
    sb_q.push_back(32'h00000004);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    start = 1'b1; op = 2'b00;
    data_in = 32'h00000003; shamt = 5'd1;
    sb_q.push_back(32'h00000006);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap", {busy, done}, 2'b10);
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_data2", data_out, 32'h00000006);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
